// File: rtl/vid2axis_rx.sv
// Video timing (VSync/DE/pixel) to AXI4-Stream video receiver.
// Pixels pass through a one-entry hold stage into a show-ahead FIFO; tuser marks SOF, tlast marks EOL.
module vid2axis_rx #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pVSync,
  input  logic              pVDE,
  input  logic [DATA_W-1:0] pData,
  output logic [DATA_W-1:0] m_axis_video_tdata,
  output logic              m_axis_video_tvalid,
  input  logic              m_axis_video_tready,
  output logic              m_axis_video_tuser,
  output logic              m_axis_video_tlast,
  input  logic              clr_ovf,
  output logic              ovf,
  output logic [15:0]       frame_cnt,
  output logic [11:0]       line_len,
  output logic [1:0]        dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;

  typedef enum logic [1:0] {
    WAIT_VS  = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2,
    DROP     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                vs_q;
  logic                hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic                hold_user_q, hold_user_d;
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic                ovf_q, ovf_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [11:0]         line_len_q, line_len_d;
  logic [11:0]         line_cnt_q, line_cnt_d;
  logic [EW-1:0]       mem_q [FIFO_DEPTH];

  logic                vs_rise;
  logic                empty;
  logic                full;
  logic                pop;
  logic                wr_en;
  logic                wr_last;
  logic                ovf_event;
  logic                accept;
  logic [11:0]         cnt_inc;
  logic [EW-1:0]       wr_entry;
  logic [EW-1:0]       head;

  // Handshake: a beat transfers on a rising edge where tvalid and tready are both 1;
  // tvalid never depends on tready and the head entry is held until it transfers.
  always_comb begin
    vs_rise   = pVSync & ~vs_q;
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop       = ~empty & m_axis_video_tready;
    wr_en     = hold_vld_q & (~full | pop);
    ovf_event = hold_vld_q & full & ~pop;
    // A sync edge closes whatever line is still in the hold stage.
    wr_last   = ~pVDE | vs_rise;
    accept    = pVDE & ~vs_rise & ~ovf_event & ((state_q == WAIT_SOF) || (state_q == ACTIVE));
    cnt_inc   = (line_cnt_q == 12'hFFF) ? 12'hFFF : line_cnt_q + 12'd1;
    wr_entry  = {hold_data_q, hold_user_q, wr_last};
    head      = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_comb begin
    state_d     = state_q;
    hold_vld_d  = accept;
    hold_data_d = hold_data_q;
    hold_user_d = hold_user_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ovf_d       = ovf_q;
    frame_cnt_d = frame_cnt_q;
    line_len_d  = line_len_q;
    line_cnt_d  = line_cnt_q;

    if (vs_rise) begin
      state_d = WAIT_SOF;
    end else if (ovf_event) begin
      state_d = DROP;
    end else if ((state_q == WAIT_SOF) && accept) begin
      state_d = ACTIVE;
    end

    if (accept) begin
      hold_data_d = pData;
      hold_user_d = (state_q == WAIT_SOF);
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (hold_user_q) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
      if (wr_last) begin
        line_len_d = cnt_inc;
        line_cnt_d = 12'd0;
      end else begin
        line_cnt_d = cnt_inc;
      end
    end else if (vs_rise) begin
      line_cnt_d = 12'd0;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // A new overflow wins over a simultaneous clear.
    if (ovf_event) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q     <= WAIT_VS;
      vs_q        <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      hold_user_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
      line_len_q  <= 12'd0;
      line_cnt_q  <= 12'd0;
    end else begin
      state_q     <= state_d;
      vs_q        <= pVSync;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      hold_user_q <= hold_user_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
      line_len_q  <= line_len_d;
      line_cnt_q  <= line_cnt_d;
    end
  end

  // Storage is not reset; the outputs below are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end
  end

  always_comb begin
    m_axis_video_tvalid = ~empty;
    m_axis_video_tdata  = empty ? '0 : head[EW-1:2];
    m_axis_video_tuser  = ~empty & head[1];
    m_axis_video_tlast  = ~empty & head[0];
    ovf                 = ovf_q;
    frame_cnt           = frame_cnt_q;
    line_len            = line_len_q;
    dbg_state           = state_q;
  end

endmodule

// File: doc/vid2axis_rx.md
VID2AXIS_RX -- requirements
Module: vid2axis_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 24, pixel width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, output FIFO entries, power of two, range 4..256.
REQ-003 SHALL have clk input 1: single clock; all logic on its rising edge.
REQ-004 SHALL have rstn input 1: reset, asynchronous, active-high (asserted when 1).
REQ-005 SHALL have pVSync input 1: vertical sync, active-high.
REQ-006 SHALL have pVDE input 1: video data enable, active-high.
REQ-007 SHALL have pData input DATA_W: pixel, valid when pVDE=1.
REQ-008 SHALL have m_axis_video_tdata output DATA_W: stream pixel.
REQ-009 SHALL have m_axis_video_tvalid output 1: stream valid.
REQ-010 SHALL have m_axis_video_tready input 1: sink ready.
REQ-011 SHALL have m_axis_video_tuser output 1: start of frame.
REQ-012 SHALL have m_axis_video_tlast output 1: end of line.
REQ-013 SHALL have clr_ovf input 1: one-cycle pulse clearing ovf.
REQ-014 SHALL have ovf output 1: sticky overflow flag.
REQ-015 SHALL have frame_cnt output 16: frames started.
REQ-016 SHALL have line_len output 12: pixel count of last completed line.

Function
REQ-017 SHALL implement states WAIT_VS, WAIT_SOF, ACTIVE, DROP.
- WAIT_VS -> WAIT_SOF on pVSync rising edge (pVSync=1, previous sample 0).
- WAIT_SOF -> ACTIVE on first pVDE=1.
- ACTIVE -> DROP on overflow.
- DROP, and every other state, -> WAIT_SOF on pVSync rising edge.
REQ-018 SHALL ignore pVDE pixels in WAIT_VS and DROP.
REQ-019 SHALL capture each accepted pixel into a hold register on the edge ending its pVDE=1 cycle, with tuser=1 only for the pixel causing WAIT_SOF->ACTIVE.
REQ-020 SHALL write the held pixel to the FIFO on the next edge, with tlast = ~pVDE in that cycle; a pixel held when a pVSync rising edge arrives is written with tlast=1.
REQ-021 SHALL give a latency of 2 cycles: pixel sampled in cycle N gives tvalid=1 in cycle N+2 when the FIFO was empty.
REQ-022 SHALL implement the FIFO as show-ahead: tvalid = ~empty; tdata/tuser/tlast from the head entry; pop on tvalid&tready.
REQ-023 SHALL hold tdata, tuser and tlast stable while tvalid=1 and tready=0.
REQ-024 SHALL accept a write when the FIFO is full and a pop occurs in the same cycle; the count is unchanged.
REQ-025 SHALL treat a write attempt with the FIFO full and no pop as overflow: pixel dropped, ovf<=1, state->DROP; the entries already queued still drain normally.
REQ-026 SHALL, on same-cycle clr_ovf and new overflow, leave ovf=1.
REQ-027 SHALL increment frame_cnt when a tuser pixel is written to the FIFO, wrapping from 0xFFFF to 0.
REQ-028 SHALL count written pixels per line and load line_len on each tlast write, saturating the count at 0xFFF.
REQ-029 SHALL treat the pointer arithmetic as modulo FIFO_DEPTH, with one extra wrap bit to distinguish full from empty.

Reset
REQ-030 SHALL, while rstn=1: state=WAIT_VS; FIFO empty; tvalid=0, tuser=0, tlast=0, tdata=0, ovf=0, frame_cnt=0, line_len=0; hold register invalid; sync edge detector=0.
REQ-031 SHALL, when rstn asserts mid-line, discard all queued and held pixels, with tvalid=0 immediately (asynchronous).
REQ-032 SHALL, after rstn deasserts, ignore pixels until a pVSync rising edge.

Verification
REQ-033 SHALL verify basic frame: pVSync pulse, then 2 lines of 4 pixels (0x000001..0x000008) with 3-cycle pVDE gaps, tready=1 -> 8 beats in order; tuser on 0x000001 only; tlast on 0x000004 and 0x000008; frame_cnt=1; line_len=4.
REQ-034 SHALL verify latency: single pixel after VSync with FIFO empty -> tvalid rises exactly 2 cycles after its pVDE cycle, tuser=1, tlast=1.
REQ-035 SHALL verify backpressure: tready=0 during a 16-pixel line, FIFO_DEPTH=16 -> no overflow; raising tready drains 16 beats with tlast on the 16th.
REQ-036 SHALL verify overflow: tready=0, 20-pixel line -> ovf=1, 16 beats delivered; following lines dropped until the next VSync; next frame delivered with tuser; clr_ovf -> ovf=0.
REQ-037 SHALL verify mid-line reset: rstn=1 for 2 cycles during a line -> tvalid=0 at once; no output until a VSync followed by pVDE; frame_cnt restarts at 1.
REQ-038 SHALL verify wrap: 65536 frames (or a forced count of 0xFFFF) -> frame_cnt wraps to 0.
